// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word widths, NOP encoding and the
// fetch-stage state and IF/ID register types.
package mips_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES        = 32'd4;
  localparam int unsigned DEFAULT_IMEM_WORDS = 74;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instruction;
    logic              valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instruction: NOP_INSTR, valid: 1'b0};

  // True when the byte address falls inside the loaded program image.
  function automatic logic in_image(input logic [WORD_W-1:0] addr, input int unsigned words);
    return {2'b00, addr[WORD_W-1:2]} < words;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_pc_register.sv
// Program counter register with load enable; resets asynchronously to RESET_PC.
module pc_register
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC selection, RUN/HALT control and the IF/ID pipeline register.
//   state | meaning
//   RUN   | fetching sequentially from the program image
//   HALT  | PC ran past the image; IF/ID fed bubbles until a branch redirects
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned       IMEM_WORDS = DEFAULT_IMEM_WORDS,
  parameter logic [WORD_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_address,
  output logic [WORD_W-1:0] imem_address,
  input  logic [WORD_W-1:0] imem_instruction,
  output logic [WORD_W-1:0] if_id_pc,
  output logic [WORD_W-1:0] if_id_instruction,
  output logic              if_id_valid,
  output logic              halted
);

  fetch_state_t      state, state_next;
  if_id_t            if_id, if_id_next;
  logic              if_id_load;
  logic              pc_load;
  logic [WORD_W-1:0] pc, pc_next, pc_plus4, branch_target;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_next),
    .q    (pc)
  );

  assign pc_plus4      = pc + INSTR_BYTES;
  assign branch_target = branch_address & ~32'h3;

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_next    = pc;
    if_id_load = 1'b0;
    if_id_next = IF_ID_BUBBLE;

    if (branch_taken) begin
      pc_load    = 1'b1;
      pc_next    = branch_target;
      if_id_load = 1'b1;
      state_next = in_image(branch_target, IMEM_WORDS) ? RUN : HALT;
    end else if (!freeze) begin
      case (state)
        RUN: begin
          if_id_load = 1'b1;
          if (in_image(pc, IMEM_WORDS)) begin
            if_id_next = '{pc: pc_plus4, instruction: imem_instruction, valid: 1'b1};
            pc_load    = 1'b1;
            pc_next    = pc_plus4;
          end else begin
            state_next = HALT;
          end
        end
        HALT: begin
          if_id_load = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      if_id <= IF_ID_BUBBLE;
    end else begin
      state <= state_next;
      if (if_id_load) begin
        if_id <= if_id_next;
      end
    end
  end

  assign imem_address      = pc;
  assign if_id_pc          = if_id.pc;
  assign if_id_instruction = if_id.instruction;
  assign if_id_valid       = if_id.valid;
  assign halted            = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a 74-word and a 4-word instance
// driven with directed vectors; a negedge monitor pops expectations and compares.
module tb_instruction_fetch_stage;

  typedef struct {
    bit          sel_b;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, rst_b = 1'b0;
  logic        freeze_a = 1'b0, freeze_b = 1'b1;
  logic        br_a = 1'b0, br_b = 1'b0;
  logic [31:0] baddr_a = '0, baddr_b = '0;
  logic [31:0] addr_a, addr_b, imem_a, imem_b;
  logic [31:0] pc_a, pc_b, instr_a, instr_b;
  logic        valid_a, valid_b, halted_a, halted_b;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;

  // Program image: words 0..2 are fixed patterns, later words encode their own address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'h1111_1111;
      30'd1:   return 32'h2222_2222;
      30'd2:   return 32'h3333_3333;
      default: return 32'hA500_0000 | a;
    endcase
  endfunction

  assign imem_a = imem_word(addr_a);
  assign imem_b = imem_word(addr_b);

  instruction_fetch_stage #(.IMEM_WORDS(74), .RESET_PC(32'd0)) dut_a (
    .clk(clk), .rst(rst_a), .freeze(freeze_a), .branch_taken(br_a),
    .branch_address(baddr_a), .imem_address(addr_a), .imem_instruction(imem_a),
    .if_id_pc(pc_a), .if_id_instruction(instr_a), .if_id_valid(valid_a), .halted(halted_a)
  );

  instruction_fetch_stage #(.IMEM_WORDS(4), .RESET_PC(32'd0)) dut_b (
    .clk(clk), .rst(rst_b), .freeze(freeze_b), .branch_taken(br_b),
    .branch_address(baddr_b), .imem_address(addr_b), .imem_instruction(imem_b),
    .if_id_pc(pc_b), .if_id_instruction(instr_b), .if_id_valid(valid_b), .halted(halted_b)
  );

  task automatic push(input bit sel_b, input string name, input logic [31:0] addr,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic valid, input logic halted);
    exp_t e;
    e.sel_b = sel_b; e.name = name; e.addr = addr; e.pc = pc;
    e.instr = instr; e.valid = valid; e.halted = halted;
    sb.push_back(e);
  endtask

  task automatic step_a(input string name, input logic frz, input logic br, input logic [31:0] ba,
                        input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] instr,
                        input logic valid, input logic halted);
    freeze_a = frz; br_a = br; baddr_a = ba;
    @(posedge clk);
    push(1'b0, name, addr, pc, instr, valid, halted);
    @(negedge clk);
  endtask

  task automatic step_b(input string name, input logic frz, input logic br, input logic [31:0] ba,
                        input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] instr,
                        input logic valid, input logic halted);
    freeze_b = frz; br_b = br; baddr_b = ba;
    @(posedge clk);
    push(1'b1, name, addr, pc, instr, valid, halted);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [97:0] act, want;
      e = sb.pop_front();
      if (e.sel_b) act = {addr_b, pc_b, instr_b, valid_b, halted_b};
      else         act = {addr_a, pc_a, instr_a, valid_a, halted_a};
      want = {e.addr, e.pc, e.instr, e.valid, e.halted};
      tests++;
      if (act !== want) begin
        failed++;
        $display("FAIL %s: got addr=%h pc=%h instr=%h v=%b h=%b, want addr=%h pc=%h instr=%h v=%b h=%b",
                 e.name, act[97:66], act[65:34], act[33:2], act[1], act[0],
                 e.addr, e.pc, e.instr, e.valid, e.halted);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    push(1'b0, "reset_a", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    push(1'b1, "reset_b", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // Sequential fetch and a two-cycle freeze at PC 8.
    step_a("fetch0",   0, 0, 0, 32'h04, 32'h04, 32'h1111_1111, 1, 0);
    step_a("fetch1",   0, 0, 0, 32'h08, 32'h08, 32'h2222_2222, 1, 0);
    step_a("freeze1",  1, 0, 0, 32'h08, 32'h08, 32'h2222_2222, 1, 0);
    step_a("freeze2",  1, 0, 0, 32'h08, 32'h08, 32'h2222_2222, 1, 0);
    step_a("resume",   0, 0, 0, 32'h0C, 32'h0C, 32'h3333_3333, 1, 0);
    step_a("fetch3",   0, 0, 0, 32'h10, 32'h10, 32'hA500_000C, 1, 0);
    // Branch wins over freeze; low address bits dropped.
    step_a("br_frz",   1, 1, 32'h23, 32'h20, 32'h00, 32'h0, 0, 0);
    step_a("br_tgt",   0, 0, 0, 32'h24, 32'h24, 32'hA500_0020, 1, 0);
    step_a("br_next",  0, 0, 0, 32'h28, 32'h28, 32'hA500_0024, 1, 0);
    // Branch out of image halts immediately.
    step_a("br_out",   0, 1, 32'h200, 32'h200, 32'h0, 32'h0, 0, 1);
    step_a("halt_hold",0, 0, 0, 32'h200, 32'h0, 32'h0, 0, 1);
    step_a("halt_frz", 1, 0, 0, 32'h200, 32'h0, 32'h0, 0, 1);
    // Last in-image word (index 73) fetches, then HALT on the next edge.
    step_a("br_last",  0, 1, 32'h124, 32'h124, 32'h0, 32'h0, 0, 0);
    step_a("last_word",0, 0, 0, 32'h128, 32'h128, 32'hA500_0124, 1, 0);
    step_a("past_end", 0, 0, 0, 32'h128, 32'h0, 32'h0, 0, 1);
    step_a("br_40",    0, 1, 32'h28, 32'h28, 32'h0, 32'h0, 0, 0);

    // Async reset mid-cycle at PC 40, checked before any further rising edge.
    freeze_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    push(1'b0, "async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_a = 1'b1;
    step_a("post_rst", 0, 0, 0, 32'h04, 32'h04, 32'h1111_1111, 1, 0);
    freeze_a = 1'b1;

    // Four-word image: run off the end, then branch back in.
    step_b("b_hold",   1, 0, 0, 32'h00, 32'h00, 32'h0, 0, 0);
    step_b("b_w0",     0, 0, 0, 32'h04, 32'h04, 32'h1111_1111, 1, 0);
    step_b("b_w1",     0, 0, 0, 32'h08, 32'h08, 32'h2222_2222, 1, 0);
    step_b("b_w2",     0, 0, 0, 32'h0C, 32'h0C, 32'h3333_3333, 1, 0);
    step_b("b_w3",     0, 0, 0, 32'h10, 32'h10, 32'hA500_000C, 1, 0);
    step_b("b_halt",   0, 0, 0, 32'h10, 32'h00, 32'h0, 0, 1);
    step_b("b_halt2",  0, 0, 0, 32'h10, 32'h00, 32'h0, 0, 1);
    step_b("b_br4",    0, 1, 32'h4, 32'h04, 32'h00, 32'h0, 0, 0);
    step_b("b_resume", 0, 0, 0, 32'h08, 32'h08, 32'h2222_2222, 1, 0);
    freeze_b = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
